// File: rtl/barrel_shifter_pipe.sv
// barrel_shifter_pipe
//   Two-stage pipelined barrel shifter with valid/ready handshakes on both
//   sides. Stage 1 registers the request after shifting by the upper bits of
//   the shift amount. Stage 2 shifts by the remaining low bits and holds the
//   registered result, err and out_valid.
//
//   Parameters : WIDTH   data width (power of two, 4..64)
//                SW      shift-amount width, $clog2(WIDTH) (derived)
//   Ports      : clk, rst (async, active-high)
//                in_valid / in_ready   request handshake
//                data, shift, dir      operand, amount, 0=left 1=right
//                mode                  00 logical, 01 arithmetic,
//                                      10 rotate, 11 reserved
//                out_valid / out_ready result handshake
//                result, err           registered result, illegal-mode flag
//   Config     : define BARREL_SHIFTER_PIPE_ROTATE_EN to implement mode 10
//                as rotate. Otherwise mode 10 is reserved like mode 11:
//                the data passes through unchanged and err is set.

module barrel_shifter_pipe #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data,
  input  logic [SW-1:0]    shift,
  input  logic             dir,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  // Stage 1 handles the upper shift bits. The low LO bits are left for stage 2.
  localparam int unsigned LO      = SW / 2;
  localparam logic [SW-1:0] LO_MASK = SW'((1 << LO) - 1);

  typedef enum logic [1:0] {
    OP_LOGIC = 2'd0,
    OP_ARITH = 2'd1,
    OP_ROT   = 2'd2,
    OP_PASS  = 2'd3
  } op_e;

  function automatic op_e decode_mode(input logic [1:0] m);
    op_e o;
    case (m)
      2'b00:   o = OP_LOGIC;
      2'b01:   o = OP_ARITH;
`ifdef BARREL_SHIFTER_PIPE_ROTATE_EN
      2'b10:   o = OP_ROT;
`endif
      default: o = OP_PASS;
    endcase
    return o;
  endfunction

  // Splitting the shift across stages is exact for every op. An arithmetic
  // right shift keeps the sign bit in the MSB, so stage 2 still fills with
  // the original sign.
  function automatic logic [WIDTH-1:0] shift_by(
    input logic [WIDTH-1:0] d,
    input logic [SW-1:0]    amt,
    input logic             right,
    input op_e              op
  );
    logic [WIDTH-1:0] r;
`ifdef BARREL_SHIFTER_PIPE_ROTATE_EN
    logic [2*WIDTH-1:0] dd;
`endif
    r = d;
    case (op)
      OP_LOGIC: begin
        if (right) r = d >> amt;
        else       r = d << amt;
      end
      OP_ARITH: begin
        if (right) r = $signed(d) >>> amt;
        else       r = d << amt;
      end
`ifdef BARREL_SHIFTER_PIPE_ROTATE_EN
      OP_ROT: begin
        dd = {d, d};
        if (right) begin
          dd = dd >> amt;
          r  = dd[WIDTH-1:0];
        end else begin
          dd = dd << amt;
          r  = dd[2*WIDTH-1:WIDTH];
        end
      end
`endif
      default: r = d;
    endcase
    return r;
  endfunction

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_data_q,  s1_data_d;
  logic [SW-1:0]    s1_rem_q,   s1_rem_d;
  logic             s1_dir_q,   s1_dir_d;
  op_e              s1_op_q,    s1_op_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q,   result_d;
  logic             err_q,      err_d;

  logic s2_advance;
  logic accept;
  op_e  in_op;

  always_comb begin
    s2_advance = !out_valid_q || out_ready;
    in_ready   = !s1_valid_q || s2_advance;
    accept     = in_valid && in_ready;
    in_op      = decode_mode(mode);

    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_rem_d    = s1_rem_q;
    s1_dir_d    = s1_dir_q;
    s1_op_d     = s1_op_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    err_d       = err_q;

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_data_d  = shift_by(data, shift & ~LO_MASK, dir, in_op);
      s1_rem_d   = shift & LO_MASK;
      s1_dir_d   = dir;
      s1_op_d    = in_op;
    end else if (s2_advance) begin
      s1_valid_d = 1'b0;
    end

    // The result and err registers load only with a real entry. When
    // out_valid is low they keep the last result.
    if (s2_advance) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        result_d = shift_by(s1_data_q, s1_rem_q, s1_dir_q, s1_op_q);
        err_d    = (s1_op_q == OP_PASS);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_rem_q    <= '0;
      s1_dir_q    <= 1'b0;
      s1_op_q     <= OP_LOGIC;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_rem_q    <= s1_rem_d;
      s1_dir_q    <= s1_dir_d;
      s1_op_q     <= s1_op_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign err       = err_q;

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Testbench for barrel_shifter_pipe (WIDTH=8). Expected results come from an
// arithmetic reference model and a scoreboard queue. Accepted requests are
// pushed onto the queue and popped when a result is delivered.

module tb_barrel_shifter_pipe;

  localparam int unsigned W = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] data;
  logic [2:0] shift;
  logic       dir;
  logic [1:0] mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       err;

  barrel_shifter_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data      (data),
    .shift     (shift),
    .dir       (dir),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] r;
    logic       e;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  bit          hold_pending = 1'b0;
  logic [7:0]  hold_r;
  logic        hold_e;
  bit          last_acc;
  bit          saw_full;

  // Reference model: plain integer arithmetic on the full shift amount.
  function automatic exp_t ref_model(input logic [7:0] d, input int s,
                                     input logic rgt, input logic [1:0] m);
    int   v;
    int   sv;
    exp_t x;
    v   = int'(d);
    sv  = d[7] ? v - 256 : v;
    x.r = d;
    x.e = 1'b0;
    case (m)
      2'b00: x.r = rgt ? 8'(v >> s) : 8'(v << s);
      2'b01: x.r = rgt ? 8'(sv >>> s) : 8'(v << s);
      2'b10: begin
`ifdef BARREL_SHIFTER_PIPE_ROTATE_EN
        x.r = rgt ? 8'((v >> s) | (v << (8 - s))) : 8'((v << s) | (v >> (8 - s)));
`else
        x.e = 1'b1;
`endif
      end
      default: x.e = 1'b1;
    endcase
    return x;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [7:0] d, input logic [2:0] s,
                       input logic r, input logic [1:0] m, input bit ordy);
    in_valid  = v;
    data      = d;
    shift     = s;
    dir       = r;
    mode      = m;
    out_ready = ordy;
  endtask

  // Called just after a falling edge. Checks the handshake state, updates
  // the scoreboard, then advances through the next rising edge to the
  // following falling edge.
  task automatic tick();
    exp_t x;
    #1;
    check_eq("in_ready", 32'(in_ready), 32'((sb.size() < 2) || out_ready));
    if (hold_pending) begin
      check_eq("hold_valid", 32'(out_valid), 32'd1);
      check_eq("hold_result", 32'(result), 32'(hold_r));
      check_eq("hold_err", 32'(err), 32'(hold_e));
    end
    hold_pending = out_valid && !out_ready;
    hold_r       = result;
    hold_e       = err;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_eq("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        x = sb.pop_front();
        check_eq("result", 32'(result), 32'(x.r));
        check_eq("err", 32'(err), 32'(x.e));
      end
    end
    last_acc = in_valid && in_ready;
    if (last_acc) sb.push_back(ref_model(data, int'(shift), dir, mode));
    if (!in_ready) saw_full = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  // A single request on an empty pipeline. It is accepted on the first edge
  // and is visible after the second edge. The output is then consumed.
  task automatic directed(input string tag, input logic [7:0] d, input logic [2:0] s,
                          input logic r, input logic [1:0] m,
                          input logic [7:0] er, input logic ee);
    drive(1'b1, d, s, r, m, 1'b1);
    tick();
    check_eq({tag, "_acc"}, 32'(last_acc), 32'd1);
    check_eq({tag, "_lat1"}, 32'(out_valid), 32'd0);
    drive(1'b0, d, s, r, m, 1'b1);
    tick();
    check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, "_result"}, 32'(result), 32'(er));
    check_eq({tag, "_err"}, 32'(err), 32'(ee));
    tick();
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      drive(1'b0, data, shift, dir, mode, 1'b1);
      tick();
    end
    check_eq(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] rd[4];
    logic [2:0] rs[4];
    logic       rr[4];
    logic [1:0] rm[4];
    int         issued;
    bit         have_req;

    rst = 1'b1;
    drive(1'b0, 8'h00, 3'd0, 1'b0, 2'b00, 1'b1);
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_result", 32'(result), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

    directed("lsl", 8'hB5, 3'd3, 1'b0, 2'b00, 8'hA8, 1'b0);
    directed("asr_neg", 8'hB5, 3'd2, 1'b1, 2'b01, 8'hED, 1'b0);
    directed("asr_pos", 8'h35, 3'd2, 1'b1, 2'b01, 8'h0D, 1'b0);
    directed("asl", 8'hB5, 3'd3, 1'b0, 2'b01, 8'hA8, 1'b0);
    directed("lsr", 8'hB5, 3'd7, 1'b1, 2'b00, 8'h01, 1'b0);
`ifdef BARREL_SHIFTER_PIPE_ROTATE_EN
    directed("ror", 8'hB5, 3'd3, 1'b1, 2'b10, 8'hB6, 1'b0);
    directed("rol", 8'hB5, 3'd3, 1'b0, 2'b10, 8'hAD, 1'b0);
`else
    directed("rot_rsv", 8'hB5, 3'd3, 1'b1, 2'b10, 8'hB5, 1'b1);
`endif
    directed("rsv", 8'h5A, 3'd4, 1'b0, 2'b11, 8'h5A, 1'b1);
    directed("after_rsv", 8'h5A, 3'd4, 1'b0, 2'b00, 8'hA0, 1'b0);
    directed("zero_shift", 8'hC3, 3'd0, 1'b1, 2'b01, 8'hC3, 1'b0);

    // Four back-to-back requests. out_ready is low in cycles 2-5.
    for (int i = 0; i < 4; i++) begin
      rd[i] = 8'($urandom);
      rs[i] = 3'($urandom);
      rr[i] = 1'($urandom);
      rm[i] = 2'($urandom_range(0, 2));
    end
    issued   = 0;
    saw_full = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (issued < 4)
        drive(1'b1, rd[issued], rs[issued], rr[issued], rm[issued], !(c >= 2 && c <= 5));
      else
        drive(1'b0, data, shift, dir, mode, !(c >= 2 && c <= 5));
      tick();
      if (last_acc) issued++;
    end
    drain("stream_drain");
    check_eq("stream_issued", 32'(issued), 32'd4);
    check_eq("stream_in_ready_low", 32'(saw_full), 32'd1);

    // Two requests in flight, then an asynchronous reset between clock edges.
    drive(1'b1, 8'h12, 3'd1, 1'b0, 2'b00, 1'b1);
    tick();
    drive(1'b1, 8'h34, 3'd2, 1'b1, 2'b00, 1'b1);
    tick();
    drive(1'b0, data, shift, dir, mode, 1'b1);
    rst = 1'b1;
    #1;
    check_eq("arst_out_valid", 32'(out_valid), 32'd0);
    check_eq("arst_result", 32'(result), 32'd0);
    check_eq("arst_err", 32'(err), 32'd0);
    check_eq("arst_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    hold_pending = 1'b0;
    #1;
    rst = 1'b0;
    directed("post_rst", 8'h81, 3'd1, 1'b1, 2'b01, 8'hC0, 1'b0);
    repeat (4) begin
      drive(1'b0, data, shift, dir, mode, 1'b1);
      tick();
    end

    // Random traffic with random backpressure. A request is held until accepted.
    have_req = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!have_req && $urandom_range(0, 9) < 7) begin
        have_req = 1'b1;
        data     = 8'($urandom);
        shift    = 3'($urandom);
        dir      = 1'($urandom);
        mode     = 2'($urandom);
      end
      drive(have_req, data, shift, dir, mode, $urandom_range(0, 9) < 7);
      tick();
      if (last_acc) have_req = 1'b0;
    end
    drain("rand_drain");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
